// File: rtl/tick_key_conditioner.sv
// Front end for the clock/calendar counter: 1 Hz tick, 50% blink square wave
// and debounced, auto-repeating one-cycle strobes for the three pushbuttons.
module tick_key_conditioner #(
    parameter int unsigned TICK_DIV   = 32'd50000000,
    parameter int unsigned DB_CYCLES  = 32'd1000000,
    parameter int unsigned RPT_DELAY  = 32'd25000000,
    parameter int unsigned RPT_PERIOD = 32'd5000000
) (
    input  logic clk,
    input  logic key0,
    input  logic key1,
    input  logic key2,
    input  logic key3,
    output logic tick,
    output logic blink,
    output logic key1_pulse,
    output logic key2_pulse,
    output logic key3_pulse
);

    typedef enum logic [2:0] {
        RELEASED   = 3'd0,
        DB_PRESS   = 3'd1,
        HELD       = 3'd2,
        REPEAT     = 3'd3,
        DB_RELEASE = 3'd4
    } key_state_t;

    localparam logic [31:0] DIV_LAST  = 32'(TICK_DIV - 32'd1);
    localparam logic [31:0] HALF_LAST = 32'((TICK_DIV / 32'd2) - 32'd1);
    localparam logic [31:0] DB_LAST   = 32'(DB_CYCLES - 32'd1);
    localparam logic [31:0] RD_LAST   = 32'(RPT_DELAY - 32'd1);
    localparam logic [31:0] RP_LAST   = 32'(RPT_PERIOD - 32'd1);

    logic [31:0] div_cnt_r;
    logic        wrap_hit_r;
    logic        half_hit_r;

    logic [2:0]  sync1_r;
    logic [2:0]  sync2_r;

    key_state_t  state_r  [3];
    key_state_t  state_nx [3];
    logic [31:0] cnt_r    [3];
    logic [31:0] cnt_nx   [3];
    logic [2:0]  pulse_r;
    logic [2:0]  pulse_nx;

    // Tick/blink divider. The terminal-count compares are registered first, so
    // tick lands on the TICK_DIV-th edge after the reset-release edge.
    always_ff @(posedge clk) begin
        if (!key0) begin
            div_cnt_r  <= 32'd0;
            wrap_hit_r <= 1'b0;
            half_hit_r <= 1'b0;
            tick       <= 1'b0;
            blink      <= 1'b0;
        end else begin
            if (div_cnt_r == DIV_LAST) begin
                div_cnt_r <= 32'd0;
            end else begin
                div_cnt_r <= div_cnt_r + 32'd1;
            end
            wrap_hit_r <= (div_cnt_r == DIV_LAST);
            half_hit_r <= (div_cnt_r == HALF_LAST);
            tick       <= wrap_hit_r;
            if (wrap_hit_r || half_hit_r) begin
                blink <= ~blink;
            end else begin
                blink <= blink;
            end
        end
    end

    // Two-flop synchronizers; reset parks them at the released (high) level.
    always_ff @(posedge clk) begin
        if (!key0) begin
            sync1_r <= 3'b111;
            sync2_r <= 3'b111;
        end else begin
            sync1_r <= {key3, key2, key1};
            sync2_r <= sync1_r;
        end
    end

    // Next-state logic for the three identical debounce/auto-repeat machines.
    always_comb begin
        pulse_nx = 3'b000;
        for (int i = 0; i < 3; i++) begin
            state_nx[i] = state_r[i];
            cnt_nx[i]   = cnt_r[i];
            case (state_r[i])
                RELEASED: begin
                    cnt_nx[i] = 32'd0;
                    if (!sync2_r[i]) begin
                        state_nx[i] = DB_PRESS;
                    end else begin
                        state_nx[i] = RELEASED;
                    end
                end
                DB_PRESS: begin
                    if (sync2_r[i]) begin
                        state_nx[i] = RELEASED;
                        cnt_nx[i]   = 32'd0;
                    end else if (cnt_r[i] == DB_LAST) begin
                        state_nx[i] = HELD;
                        cnt_nx[i]   = 32'd0;
                        pulse_nx[i] = 1'b1;
                    end else begin
                        cnt_nx[i] = cnt_r[i] + 32'd1;
                    end
                end
                HELD: begin
                    if (sync2_r[i]) begin
                        state_nx[i] = DB_RELEASE;
                        cnt_nx[i]   = 32'd0;
                    end else if (cnt_r[i] == RD_LAST) begin
                        state_nx[i] = REPEAT;
                        cnt_nx[i]   = 32'd0;
                        pulse_nx[i] = 1'b1;
                    end else begin
                        cnt_nx[i] = cnt_r[i] + 32'd1;
                    end
                end
                REPEAT: begin
                    if (sync2_r[i]) begin
                        state_nx[i] = DB_RELEASE;
                        cnt_nx[i]   = 32'd0;
                    end else if (cnt_r[i] == RP_LAST) begin
                        cnt_nx[i]   = 32'd0;
                        pulse_nx[i] = 1'b1;
                    end else begin
                        cnt_nx[i] = cnt_r[i] + 32'd1;
                    end
                end
                DB_RELEASE: begin
                    // A low glitch while releasing restarts the repeat delay.
                    if (!sync2_r[i]) begin
                        state_nx[i] = HELD;
                        cnt_nx[i]   = 32'd0;
                    end else if (cnt_r[i] == DB_LAST) begin
                        state_nx[i] = RELEASED;
                        cnt_nx[i]   = 32'd0;
                    end else begin
                        cnt_nx[i] = cnt_r[i] + 32'd1;
                    end
                end
                default: begin
                    state_nx[i] = RELEASED;
                    cnt_nx[i]   = 32'd0;
                end
            endcase
        end
    end

    // Key state, counters and registered strobes.
    always_ff @(posedge clk) begin
        if (!key0) begin
            for (int i = 0; i < 3; i++) begin
                state_r[i] <= RELEASED;
                cnt_r[i]   <= 32'd0;
            end
            pulse_r <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                state_r[i] <= state_nx[i];
                cnt_r[i]   <= cnt_nx[i];
            end
            pulse_r <= pulse_nx;
        end
    end

    assign key1_pulse = pulse_r[0];
    assign key2_pulse = pulse_r[1];
    assign key3_pulse = pulse_r[2];

endmodule

// File: doc/tick_key_conditioner.md
Name: tick_key_conditioner

Overview:
Front-end stage that feeds the clock/calendar counter block. It divides the board clock into a one-cycle 1 Hz count tick and a 50% blink square wave. It also turns the raw active-low pushbuttons key1..key3 into clean one-cycle press pulses, with auto-repeat while a key is held. The downstream counter then advances on single-cycle strobes instead of sampling raw keys every clock.

Parameters:
TICK_DIV, 50000000, clk cycles per tick period; even, >=4
DB_CYCLES, 1000000, consecutive stable cycles needed to accept a key change (20 ms); >=2
RPT_DELAY, 25000000, cycles from accepted press to first auto-repeat pulse (0.5 s); >=2
RPT_PERIOD, 5000000, cycles between subsequent auto-repeat pulses (0.1 s); >=2

Ports:
clk  in  1  board clock, all logic on rising edge
key0  in  1  reset, synchronous, active-low
key1  in  1  raw pushbutton, active-low, asynchronous to clk
key2  in  1  raw pushbutton, active-low, asynchronous to clk
key3  in  1  raw pushbutton, active-low, asynchronous to clk
tick  out  1  one-cycle pulse, once every TICK_DIV cycles
blink  out  1  square wave, period TICK_DIV, 50% duty
key1_pulse  out  1  one-cycle press/repeat strobe for key1
key2_pulse  out  1  one-cycle press/repeat strobe for key2
key3_pulse  out  1  one-cycle press/repeat strobe for key3

Behaviour:
- Reset (key0 low at a rising edge):
  - tick, blink and all key pulses go to 0.
  - Divider counter and all key counters go to 0.
  - Synchronizer flops go to 1 (released).
  - All key FSMs go to RELEASED.
  - Reset is honoured mid-operation: the cycle after, all state is as above.
- Divider:
  - div_cnt counts 0..TICK_DIV-1 and wraps.
  - tick is registered high in the cycle after div_cnt==TICK_DIV-1 was seen.
  - First tick is high after the TICK_DIV-th rising edge following reset release.
- blink:
  - Toggles at the same edges that raise tick, and at the edge after div_cnt==TICK_DIV/2-1.
  - So blink rises TICK_DIV/2 cycles after reset release, and each falling edge of blink coincides with tick.
- Synchronizer: each keyN passes through 2 flops; the FSM consumes the second flop (s).
- Per-key FSM, three independent identical instances, one cycle-counter each:
  - RELEASED: s==0 -> DB_PRESS, cnt=0.
  - DB_PRESS:
    - s==1 -> RELEASED, no pulse.
    - Otherwise cnt++.
    - When cnt==DB_CYCLES-1: -> HELD, cnt=0, pulse=1 for one cycle.
  - HELD:
    - s==1 -> DB_RELEASE, cnt=0.
    - Otherwise cnt++.
    - When cnt==RPT_DELAY-1: -> REPEAT, cnt=0, pulse=1.
  - REPEAT:
    - s==1 -> DB_RELEASE, cnt=0.
    - Otherwise cnt++.
    - When cnt==RPT_PERIOD-1: cnt=0, pulse=1.
  - DB_RELEASE:
    - s==0 -> HELD, cnt=0, no pulse (a release glitch restarts the repeat delay).
    - Otherwise cnt++.
    - When cnt==DB_CYCLES-1: -> RELEASED.
    - No pulses in this state.
- Timing: a key held low continuously from rising edge 0 produces pulses at edges:
  - DB_CYCLES+2 (press),
  - then DB_CYCLES+2+RPT_DELAY,
  - then every RPT_PERIOD cycles after that.
- Pulses are registered and exactly one cycle wide. Never two consecutive cycles high, given the parameter minimums.
- Keys are fully independent; any combination of pulses, including with tick, may assert in the same cycle.
- A key held across reset release is treated as a fresh press and yields a press pulse DB_CYCLES+2 edges after release.
- Widths: all counters are 32-bit unsigned; no overflow is reachable within the parameter limits.

Test Plan:
(bench params: TICK_DIV=10, DB_CYCLES=4, RPT_DELAY=12, RPT_PERIOD=5; edge numbers counted from the first edge with key0 high)
- Free run, keys high, 40 cycles -> tick high at edges 10,20,30,40 only; blink rises at 5,15,25,35 and falls at 10,20,30,40; all key pulses 0.
- key1 low at edges 0-7, then high -> key1_pulse high only at edge 6; no repeat; key2_pulse and key3_pulse stay 0.
- key2 bounce: low 2 cycles, high 1, low 3, high 1, then steady low from edge 10 -> no pulse before edge 16; single key2_pulse at edge 16.
- key3 held low at edges 0-39, released at edge 40 -> key3_pulse at exactly 6,18,23,28,33,38; none afterwards.
- key1 held, then a 1-cycle high glitch at edge 20 -> no extra pulse; FSM returns to HELD; next key1_pulse 12 cycles after the glitch is absorbed, not on the old repeat grid.
- Reset mid-hold: key1 held, key0 low for 1 cycle at edge 20 -> the next cycle, all outputs are 0 and blink is 0; tick restarts (first tick at 10 edges after release); key1_pulse at edge 6 relative to release.
